// File: rtl/tx_pkg.sv
// rtl/tx_pkg.sv - shared state type and line levels for the framed serial transmitter
package tx_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic IDLE_LEVEL  = 1'b1;
  localparam logic START_LEVEL = 1'b0;
  localparam logic STOP_LEVEL  = 1'b1;

endpackage

// File: rtl/piso_tx4_if.sv
// rtl/piso_tx4_if.sv - load handshake and serial line bundle for piso_tx4
interface piso_tx4_if #(
  parameter int WIDTH = 4
);

  logic             Load;
  logic [WIDTH-1:0] Din;
  logic             Ready;
  logic             Sout;
  logic             Busy;
  logic             Done;

  // Datapath side: offers words, watches the frame status
  modport master (
    output Load,
    output Din,
    input  Ready,
    input  Sout,
    input  Busy,
    input  Done
  );

  // Transmitter side
  modport slave (
    input  Load,
    input  Din,
    output Ready,
    output Sout,
    output Busy,
    output Done
  );

endinterface

// File: rtl/piso_shift.sv
// rtl/piso_shift.sv - WIDTH-bit load/shift-right register with LSB serial output
module piso_shift #(
  parameter int WIDTH = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             shift_i,
  input  logic [WIDTH-1:0] din_i,
  output logic             sout_o
);

  logic [WIDTH-1:0] shift_q;
  logic [WIDTH-1:0] shift_d;

  // Load has priority over shift so a back-to-back word never loses its LSB
  always_comb begin
    shift_d = shift_q;
    if (load_i) begin
      shift_d = din_i;
    end else if (shift_i) begin
      shift_d = {1'b0, shift_q[WIDTH-1:1]};
    end
  end

  // Register with asynchronous clear
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      shift_q <= '0;
    end else begin
      shift_q <= shift_d;
    end
  end

  assign sout_o = shift_q[0];

endmodule

// File: rtl/piso_tx4.sv
// rtl/piso_tx4.sv - framed PISO transmitter (start, data LSB first, optional even parity via PISO_TX4_PARITY_EN, stop)
module piso_tx4
  import tx_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic     Clk,
  input  logic     Rn,
  piso_tx4_if.slave bus
);

  localparam int              CW       = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]   LAST_BIT = CW'(WIDTH - 1);

  tx_state_e     state_q;
  logic [CW-1:0] cnt_q;
  logic          sout_q;
  logic          ready_q;
  logic          busy_q;
  logic          done_q;
`ifdef PISO_TX4_PARITY_EN
  logic          par_q;
`endif

  logic accept;
  logic shift_en;
  logic shift_lsb;

  // Ready is a registered decode, so acceptance only depends on Load combinationally
  assign accept   = ready_q & bus.Load;
  // The register advances on the START exit edge too, so that it always holds the next bit to send
  assign shift_en = (state_q == START) || (state_q == DATA);

  piso_shift #(
    .WIDTH (WIDTH)
  ) u_shift (
    .clk_i   (Clk),
    .rst_ni  (Rn),
    .load_i  (accept),
    .shift_i (shift_en),
    .din_i   (bus.Din),
    .sout_o  (shift_lsb)
  );

  // Frame sequencer: state, bit counter, parity and all registered line/status outputs
  always_ff @(posedge Clk or negedge Rn) begin
    if (!Rn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      sout_q  <= IDLE_LEVEL;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
`ifdef PISO_TX4_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE, STOP: begin
          if (accept) begin
            state_q <= START;
            cnt_q   <= '0;
            sout_q  <= START_LEVEL;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
`ifdef PISO_TX4_PARITY_EN
            par_q   <= 1'b0;
`endif
          end else begin
            state_q <= IDLE;
            sout_q  <= IDLE_LEVEL;
            ready_q <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
          end
        end

        START: begin
          state_q <= DATA;
          cnt_q   <= '0;
          sout_q  <= shift_lsb;
`ifdef PISO_TX4_PARITY_EN
          par_q   <= shift_lsb;
`endif
        end

        DATA: begin
          cnt_q <= cnt_q + 1'b1;
          if (cnt_q == LAST_BIT) begin
`ifdef PISO_TX4_PARITY_EN
            state_q <= PARITY;
            sout_q  <= par_q;
`else
            state_q <= STOP;
            sout_q  <= STOP_LEVEL;
            ready_q <= 1'b1;
            done_q  <= 1'b1;
`endif
          end else begin
            sout_q <= shift_lsb;
`ifdef PISO_TX4_PARITY_EN
            par_q  <= par_q ^ shift_lsb;
`endif
          end
        end

`ifdef PISO_TX4_PARITY_EN
        PARITY: begin
          state_q <= STOP;
          sout_q  <= STOP_LEVEL;
          ready_q <= 1'b1;
          done_q  <= 1'b1;
        end
`endif

        // Unreachable encodings (and PARITY when it is not built) fall back to a quiet line
        default: begin
          state_q <= IDLE;
          sout_q  <= IDLE_LEVEL;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.Sout  = sout_q;
  assign bus.Ready = ready_q;
  assign bus.Busy  = busy_q;
  assign bus.Done  = done_q;

endmodule

// File: tb/tb_piso_tx4.sv
// tb/tb_piso_tx4.sv - self-checking bench for piso_tx4 against a frame-level reference model
module tb_piso_tx4;

  localparam int W = 4;
`ifdef PISO_TX4_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif
  localparam int FL = W + 2 + PAR;

  logic clk = 1'b0;
  logic rn  = 1'b0;
  int   n_assert = 0;
  int   n_fail   = 0;

  piso_tx4_if #(.WIDTH(W)) bus ();

  piso_tx4 #(.WIDTH(W)) dut (
    .Clk (clk),
    .Rn  (rn),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, " Sout"},  bus.Sout,  1'b1);
    chk({tag, " Ready"}, bus.Ready, 1'b1);
    chk({tag, " Busy"},  bus.Busy,  1'b0);
    chk({tag, " Done"},  bus.Done,  1'b0);
  endtask

  // Caller has driven Load=1/Din=d before the accepting edge. Checks every cycle of
  // the frame against a bit list built from the framing rules. chain keeps Load high
  // and presents nd in the stop cycle; poke fires a Load of all-ones mid-data.
  task automatic tx_frame(input logic [W-1:0] d, input bit chain,
                          input logic [W-1:0] nd, input bit poke);
    logic exp_q[$];
    exp_q.push_back(1'b0);
    for (int i = 0; i < W; i++) exp_q.push_back(d[i]);
    if (PAR != 0) exp_q.push_back(^d);
    exp_q.push_back(1'b1);
    for (int j = 0; j < FL; j++) begin
      @(negedge clk);
      chk($sformatf("f%0h c%0d Sout", d, j),  bus.Sout,  exp_q[j]);
      chk($sformatf("f%0h c%0d Busy", d, j),  bus.Busy,  1'b1);
      chk($sformatf("f%0h c%0d Done", d, j),  bus.Done,  j == FL - 1);
      chk($sformatf("f%0h c%0d Ready", d, j), bus.Ready, j == FL - 1);
      bus.Din = W'($urandom);
      if (chain) begin
        bus.Load = 1'b1;
        if (j == FL - 1) bus.Din = nd;
      end else if (poke && j == 2) begin
        bus.Load = 1'b1;
        bus.Din  = '1;
      end else begin
        bus.Load = 1'b0;
      end
    end
  endtask

  initial begin
    logic [W-1:0] d;
    logic [W-1:0] nd;
    bit           chain;

    bus.Load = 1'b0;
    bus.Din  = '0;

    #12;
    chk_idle("in_reset");
    @(negedge clk);
    rn = 1'b1;
    repeat (10) begin
      @(negedge clk);
      chk_idle("idle");
    end

    bus.Load = 1'b1;
    bus.Din  = 4'b1011;
    tx_frame(4'b1011, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk_idle("after_1011");

    bus.Load = 1'b1;
    bus.Din  = 4'hA;
    tx_frame(4'hA, 1'b1, 4'h5, 1'b0);
    tx_frame(4'h5, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk_idle("after_b2b");

    bus.Load = 1'b1;
    bus.Din  = 4'h3;
    tx_frame(4'h3, 1'b0, '0, 1'b1);
    repeat (3) begin
      @(negedge clk);
      chk_idle("no_queued_frame");
    end

    bus.Load = 1'b1;
    bus.Din  = 4'hB;
    @(negedge clk);
    bus.Load = 1'b0;
    chk("mid start", bus.Sout, 1'b0);
    @(negedge clk);
    @(negedge clk);
    @(negedge clk);
    chk("mid bit2", bus.Sout, 1'b0);
    #2 rn = 1'b0;
    #1 chk_idle("async_rst");
    @(negedge clk);
    chk_idle("held_rst");
    rn       = 1'b1;
    bus.Load = 1'b1;
    bus.Din  = 4'h6;
    tx_frame(4'h6, 1'b0, '0, 1'b0);
    @(negedge clk);
    chk_idle("after_rst_frame");

    d        = W'($urandom);
    bus.Load = 1'b1;
    bus.Din  = d;
    for (int i = 0; i < 8; i++) begin
      chain = (i < 7) ? bit'($urandom_range(0, 1)) : 1'b0;
      nd    = W'($urandom);
      tx_frame(d, chain, nd, 1'b0);
      if (!chain) begin
        @(negedge clk);
        chk_idle("rand_gap");
        if (i < 7) begin
          bus.Load = 1'b1;
          bus.Din  = nd;
        end
      end
      d = nd;
    end
    @(negedge clk);
    chk_idle("final");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/piso_tx4.md
# piso_tx4

Parallel-in, serial-out framed transmitter. It accepts a WIDTH-bit word through a ready/load handshake and shifts it out on a single line: start bit, data LSB first, optional even parity, then stop bit. It is the sending end of the serial link whose receive side captures bits into the team's latch/flip-flop storage chain. It sits between the parallel datapath and the serial pin.

## Interface
- WIDTH, default 4: data word width in bits; legal range 2..16.
- Clk  input  1  single clock; all state changes on rising edge.
- Rn  input  1  asynchronous, active-low reset.
- Load  input  1  request to send Din; accepted only when Ready=1 at a rising edge.
- Din  input  WIDTH  parallel word; sampled only on the accepting edge.
- Ready  output  1  block can accept a word on this edge.
- Sout  output  1  serial line; idles high; registered.
- Busy  output  1  a frame is in progress (start through stop).
- Done  output  1  one-cycle pulse during the stop-bit cycle.

## Operation
- States: IDLE, START, DATA, PARITY (only with parity enabled), STOP.
- IDLE: Sout=1, Ready=1, Busy=0. Load=1 at an edge → capture Din into shift register, clear parity accumulator, go to START.
- START: Sout=0 for one cycle → DATA, bit counter=0.
- DATA: Sout=shift[0]; each edge shifts right by one, accumulates parity (XOR), and increments the counter. After the WIDTH-th bit → PARITY, or → STOP without parity.
- PARITY: Sout = XOR of all data bits (even parity: total ones including the parity bit is even) → STOP.
- STOP: Sout=1, Done=1, Ready=1. Load=1 at this edge → capture new Din, go directly to START (back-to-back frames, no idle gap). Otherwise → IDLE.
- Load while Ready=0 is ignored and not queued. Din changes after capture do not affect the current frame.
- Busy=1 in START, DATA, PARITY, STOP.
- Bit counter width is $clog2(WIDTH+1). No wrap-around is possible because the counter is cleared on every START.

## Timing
- Reset (Rn=0, asynchronous, any state including mid-frame): state=IDLE, Sout=1, Ready=1, Busy=0, Done=0, shift register and counter cleared. The frame in flight is aborted with no partial stop bit.
- Release of Rn takes effect at the first rising edge with Rn=1. Load on that edge is accepted.
- Accept at edge k: Sout=0 (start) from edge k to edge k+1. Data bit i spans edges k+1+i to k+2+i.
- Frame length: WIDTH+3 cycles with parity, WIDTH+2 cycles without. Throughput when back-to-back is one frame per frame length.
- Ready, Busy, Done, and Sout are all registered-state decodes. They have no combinational path from Load or Din.

## Configuration
- PISO_TX4_PARITY_EN defined: the PARITY state and parity accumulator are compiled in, and the frame is start + WIDTH data + parity + stop.
- Undefined: there is no PARITY state and no parity logic. DATA goes straight to STOP, and the frame is start + WIDTH data + stop.

## Structure
- Shared package tx_pkg holds:
  - the state enum typedef (IDLE, START, DATA, PARITY, STOP);
  - constants IDLE_LEVEL=1'b1, START_LEVEL=1'b0, STOP_LEVEL=1'b1.
- One sub-module, piso_shift: WIDTH-bit load/shift-right register with a serial LSB output, a load enable, a shift enable, and async active-low clear.
- The FSM, the counter, and the parity logic live in piso_tx4.

## Test plan
- Reset and idle: hold Rn=0, then release with Load=0 for 10 cycles → Sout=1, Ready=1, Busy=0, Done=0 throughout.
- Single frame, WIDTH=4, Din=4'b1011, parity on: Sout sequence is 0,1,1,0,1,1,1 on successive cycles. Done=1 only on the 7th cycle, and Ready=0 during cycles 1–6.
- Same stimulus with parity off: Sout sequence is 0,1,1,0,1,1, with Done on the 6th cycle.
- Back-to-back: Load held high, Din=4'hA then 4'h5 (5 presented during STOP) → second start bit immediately follows the first stop bit. Serial data reads 0,1,0,1 then 1,0,1,0. Parity bits are 0 and 0.
- Ignored load: pulse Load with Din=4'hF during DATA of a 4'h3 frame → transmitted data stays 1,1,0,0 and no second frame follows.
- Reset mid-frame: assert Rn=0 during data bit 2 → Sout goes to 1 asynchronously, and Ready=1, Busy=0. After release, a new Load of 4'h6 produces a clean full frame.
